// File: rtl/writeback_commit.sv
`default_nettype none
// writeback_commit: commit stage after execute. Retires results to GPR/FPR, drives the forwarding
// bus and the architectural PC, and stalls upstream across load latency and UART waits.
module writeback_commit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          LOAD_LATENCY = 1,
    parameter int          CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [31:0]          d,
    input  logic [31:0]          npc,
    input  logic [1:0]           rw,
    input  logic [4:0]           rd,
    input  logic                 is_load,
    input  logic                 uart_state,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          pc,
    output logic                 wb_we_gpr,
    output logic                 wb_we_fpr,
    output logic [4:0]           wb_addr,
    output logic [31:0]          wb_data,
    output logic [31:0]          ew_d,
    output logic [1:0]           ew_rw,
    output logic [4:0]           ew_rd,
    output logic [CNT_WIDTH-1:0] retired,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        UART_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] LOAD_CNT_INIT = 3'(LOAD_LATENCY);

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_next;
    logic       commit;
    logic [1:0] fwd_rw;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // start is only honoured in IDLE; a UART op outranks the load flag.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (uart_state) begin
                        state_next = UART_WAIT;
                    end else if (is_load) begin
                        state_next    = LOAD_WAIT;
                        wait_cnt_next = LOAD_CNT_INIT;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                wait_cnt_next = wait_cnt - 3'd1;
                if (wait_cnt == 3'd1) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            UART_WAIT: begin
                if (!uart_state) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Writes to GPR r0 and the reserved file code are not forwarded.
    always_comb begin
        fwd_rw = rw;
        if (rw == 2'b11 || (rw == 2'b01 && rd == 5'd0)) begin
            fwd_rw = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pc           <= RESET_PC;
            wb_we_gpr    <= 1'b0;
            wb_we_fpr    <= 1'b0;
            wb_addr      <= 5'd0;
            wb_data      <= 32'd0;
            ew_d         <= 32'd0;
            ew_rw        <= 2'b00;
            ew_rd        <= 5'd0;
            retired      <= '0;
            stall_cycles <= '0;
        end else begin
            busy      <= (state_next != IDLE);
            done      <= commit;
            wb_we_gpr <= commit && (rw == 2'b01) && (rd != 5'd0);
            wb_we_fpr <= commit && (rw == 2'b10);
            if (commit) begin
                pc      <= npc;
                wb_addr <= rd;
                wb_data <= d;
                ew_d    <= d;
                ew_rd   <= rd;
                ew_rw   <= fwd_rw;
                retired <= retired + CNT_WIDTH'(1);
            end
            if (state != IDLE) begin
                stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_commit.sv
`default_nettype none
// Bench for writeback_commit: transaction-level reference model checked every cycle, plus directed literals.
module tb_writeback_commit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          LAT      = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] d = '0;
    logic [31:0] npc = '0;
    logic [1:0]  rw = '0;
    logic [4:0]  rd = '0;
    logic        is_load = 1'b0;
    logic        uart_state = 1'b0;
    logic        busy, done, wb_we_gpr, wb_we_fpr;
    logic [31:0] pc, wb_data, ew_d, retired, stall_cycles;
    logic [4:0]  wb_addr, ew_rd;
    logic [1:0]  ew_rw;

    int vectors = 0;
    int miscompares = 0;

    writeback_commit #(.RESET_PC(RESET_PC), .LOAD_LATENCY(LAT), .CNT_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start(start), .d(d), .npc(npc), .rw(rw), .rd(rd),
        .is_load(is_load), .uart_state(uart_state), .busy(busy), .done(done), .pc(pc),
        .wb_we_gpr(wb_we_gpr), .wb_we_fpr(wb_we_fpr), .wb_addr(wb_addr), .wb_data(wb_data),
        .ew_d(ew_d), .ew_rw(ew_rw), .ew_rd(ew_rd), .retired(retired), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding instruction, described by what it waits for and for how long.
    bit          m_pending;
    bit          m_is_uart;
    int          m_age;
    logic        m_done, m_we_gpr, m_we_fpr;
    logic [31:0] m_pc, m_wb_data, m_ew_d, m_retired, m_stall;
    logic [4:0]  m_wb_addr, m_ew_rd;
    logic [1:0]  m_ew_rw;

    always @(posedge clk or negedge rstn) begin
        bit retire;
        if (!rstn) begin
            m_pending = 0; m_is_uart = 0; m_age = 0;
            m_done = 0; m_we_gpr = 0; m_we_fpr = 0;
            m_pc = RESET_PC; m_wb_data = 0; m_ew_d = 0; m_retired = 0; m_stall = 0;
            m_wb_addr = 0; m_ew_rd = 0; m_ew_rw = 0;
        end else begin
            retire = 0;
            if (m_pending) begin
                m_stall = m_stall + 1;
                m_age   = m_age + 1;
                if (m_is_uart ? !uart_state : (m_age == LAT)) begin
                    retire    = 1;
                    m_pending = 0;
                end
            end else if (start) begin
                if (uart_state) begin
                    m_pending = 1; m_is_uart = 1; m_age = 0;
                end else if (is_load) begin
                    m_pending = 1; m_is_uart = 0; m_age = 0;
                end else begin
                    retire = 1;
                end
            end
            m_done   = retire;
            m_we_gpr = retire && rw == 2'b01 && rd != 0;
            m_we_fpr = retire && rw == 2'b10;
            if (retire) begin
                m_pc      = npc;
                m_wb_addr = rd;
                m_wb_data = d;
                m_ew_d    = d;
                m_ew_rd   = rd;
                m_ew_rw   = (rw == 2'b10 || (rw == 2'b01 && rd != 0)) ? rw : 2'b00;
                m_retired = m_retired + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, m_pending});
        check("done", {31'd0, done}, {31'd0, m_done});
        check("pc", pc, m_pc);
        check("wb_we_gpr", {31'd0, wb_we_gpr}, {31'd0, m_we_gpr});
        check("wb_we_fpr", {31'd0, wb_we_fpr}, {31'd0, m_we_fpr});
        check("wb_addr", {27'd0, wb_addr}, {27'd0, m_wb_addr});
        check("wb_data", wb_data, m_wb_data);
        check("ew_d", ew_d, m_ew_d);
        check("ew_rw", {30'd0, ew_rw}, {30'd0, m_ew_rw});
        check("ew_rd", {27'd0, ew_rd}, {27'd0, m_ew_rd});
        check("retired", retired, m_retired);
        check("stall_cycles", stall_cycles, m_stall);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] f, input logic [4:0] r, input logic [31:0] data,
                         input logic [31:0] next_pc, input logic ld, input logic ua);
        start = 1'b1; rw = f; rd = r; d = data; npc = next_pc; is_load = ld; uart_state = ua;
    endtask

    initial begin
        logic [31:0] s0;
        logic [31:0] r0;
        repeat (3) tick();
        check("reset_pc", pc, RESET_PC);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        tick();

        // Plain GPR write
        issue(2'b01, 5'd3, 32'h1234, 32'h8, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t1_we_gpr", {31'd0, wb_we_gpr}, 32'd1);
        check("t1_wb_addr", {27'd0, wb_addr}, 32'd3);
        check("t1_wb_data", wb_data, 32'h1234);
        check("t1_ew_rw", {30'd0, ew_rw}, 32'd1);
        check("t1_pc", pc, 32'h8);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_retired", retired, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd0);
        tick();
        check("t1_done_drop", {31'd0, done}, 32'd0);
        check("t1_ew_hold", ew_d, 32'h1234);

        // GPR r0: retires without writing or forwarding
        issue(2'b01, 5'd0, 32'hFFFF, 32'hC, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_we_gpr", {31'd0, wb_we_gpr}, 32'd0);
        check("t2_ew_rw", {30'd0, ew_rw}, 32'd0);
        check("t2_pc", pc, 32'hC);

        // Reserved file code and no-destination both retire silently
        issue(2'b11, 5'd7, 32'h77, 32'h10, 1'b0, 1'b0);
        tick();
        issue(2'b00, 5'd9, 32'h99, 32'h14, 1'b0, 1'b0);
        check("t2b_ew_rw", {30'd0, ew_rw}, 32'd0);
        check("t2b_we_fpr", {31'd0, wb_we_fpr}, 32'd0);
        tick();
        start = 1'b0;
        check("t2c_pc", pc, 32'h14);
        check("t2c_retired", retired, 32'd4);

        // Load: d becomes valid one cycle after start
        s0 = stall_cycles;
        issue(2'b01, 5'd4, 32'h1111, 32'h20, 1'b1, 1'b0);
        tick();
        start = 1'b0; is_load = 1'b0; d = 32'hCAFE;
        check("t3_busy", {31'd0, busy}, 32'd1);
        check("t3_no_early", {31'd0, done}, 32'd0);
        tick();
        check("t3_wb_data", wb_data, 32'hCAFE);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_busy_end", {31'd0, busy}, 32'd0);
        check("t3_stall", stall_cycles - s0, 32'd1);

        // UART IN: uart_state high for 10 cycles including the start cycle; a stray start is ignored
        s0 = stall_cycles;
        issue(2'b01, 5'd5, 32'h0, 32'h24, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("t4_no_early", {31'd0, done}, 32'd0);
            start = (i == 4);
            tick();
        end
        start = 1'b0; uart_state = 1'b0; d = 32'h41;
        tick();
        check("t4_wb_data", wb_data, 32'h41);
        check("t4_wb_addr", {27'd0, wb_addr}, 32'd5);
        check("t4_we_gpr", {31'd0, wb_we_gpr}, 32'd1);
        check("t4_stall", stall_cycles - s0, 32'd10);
        check("t4_pc", pc, 32'h24);

        // Reset while waiting on UART
        issue(2'b01, 5'd6, 32'h55, 32'h28, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        check("t5_pc", pc, RESET_PC);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_we", {31'd0, wb_we_gpr}, 32'd0);
        check("t5_retired", retired, 32'd0);
        uart_state = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        issue(2'b01, 5'd8, 32'hABCD, 32'h40, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t5_fresh_data", wb_data, 32'hABCD);
        check("t5_fresh_pc", pc, 32'h40);

        // Back-to-back FPR writes
        r0 = retired;
        issue(2'b10, 5'd1, 32'hF1, 32'h44, 1'b0, 1'b0);
        tick();
        check("t6_we_fpr1", {31'd0, wb_we_fpr}, 32'd1);
        check("t6_ew_rd1", {27'd0, ew_rd}, 32'd1);
        issue(2'b10, 5'd2, 32'hF2, 32'h48, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        check("t6_we_fpr2", {31'd0, wb_we_fpr}, 32'd1);
        check("t6_ew_rd2", {27'd0, ew_rd}, 32'd2);
        check("t6_retired", retired - r0, 32'd2);
        check("t6_ew_rw", {30'd0, ew_rw}, 32'd2);
        tick();
        check("t6_we_drop", {31'd0, wb_we_fpr}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
